factorial_engine: RTL and testbench

//  Parametrised iterative factorial unit; next generation of the Go/Done/Err factorial top.

---
 rtl/factorial_engine_if.sv | 30 +++
 rtl/factorial_engine.sv | 96 +++++++++
 tb/tb_factorial_engine.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/factorial_engine_if.sv
// Go/Done handshake bundle between a host FSM and factorial_engine.
//   Go    host -> engine   start request
//   Clr   host -> engine   synchronous abort back to IDLE
//   n     host -> engine   operand, captured when Go is accepted
//   Busy  engine -> host   computation in progress
//   Done  engine -> host   result valid on nF
//   Err   engine -> host   operand rejected or result overflowed
//   nF    engine -> host   n!, zero unless Done
interface factorial_engine_if #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  Go;
    logic                  Clr;
    logic [N_WIDTH-1:0]    n;
    logic                  Busy;
    logic                  Done;
    logic                  Err;
    logic [DATA_WIDTH-1:0] nF;

    modport master (
        output Go, Clr, n,
        input  Busy, Done, Err, nF
    );

    modport slave (
        input  Go, Clr, n,
        output Busy, Done, Err, nF
    );
endinterface

// File: rtl/factorial_engine.sv
// Iterative factorial unit: one multiply per clock, counting the operand
// down to 1 while accumulating the product.
//   CLK    clock, rising edge
//   RST_n  asynchronous active-low reset
//   bus    factorial_engine_if slave (Go, Clr, n in; Busy, Done, Err, nF out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Go
//   CALC  | multiplying R by CNT, decrementing CNT each cycle
//   DONE  | nF = R holds the result until Clr or a new Go
//   ERR   | n above MAX_N or product overflowed; nF forced to 0
module factorial_engine #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_N      = 12
) (
    input  logic              CLK,
    input  logic              RST_n,
    factorial_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   r_q, r_d;
    logic [N_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] prod;
    logic                    n_too_big;

    // Full double-width product so overflow is caught exactly, whatever MAX_N is.
    assign prod = {{DATA_WIDTH{1'b0}}, r_q} *
                  {{(2*DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};

    assign n_too_big = {{(32-N_WIDTH){1'b0}}, bus.n} > 32'(MAX_N);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        if (bus.Clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                CALC: begin
                    if (cnt_q <= N_WIDTH'(1)) begin
                        state_d = DONE;
                    end else if (prod[2*DATA_WIDTH-1:DATA_WIDTH] != '0) begin
                        // R keeps the last good partial product
                        state_d = ERR;
                    end else begin
                        r_d   = prod[DATA_WIDTH-1:0];
                        cnt_d = cnt_q - N_WIDTH'(1);
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all accept a new request directly
                    if (bus.Go) begin
                        if (n_too_big) begin
                            state_d = ERR;
                        end else begin
                            state_d = CALC;
                            cnt_d   = bus.n;
                            r_d     = DATA_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.Busy = (state_q == CALC);
        bus.Done = (state_q == DONE);
        bus.Err  = (state_q == ERR);
        bus.nF   = (state_q == DONE) ? r_q : '0;
    end

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: one instance with MAX_N=12 and one
// with MAX_N=15 to reach the multiply-overflow path.
module tb_factorial_engine;

    logic CLK;
    logic RST_n;
    int   vecs;
    int   errs;

    factorial_engine_if #(.N_WIDTH(4), .DATA_WIDTH(32)) if12 ();
    factorial_engine_if #(.N_WIDTH(4), .DATA_WIDTH(32)) if15 ();

    factorial_engine #(.N_WIDTH(4), .DATA_WIDTH(32), .MAX_N(12)) u_dut12 (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (if12)
    );

    factorial_engine #(.N_WIDTH(4), .DATA_WIDTH(32), .MAX_N(15)) u_dut15 (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (if15)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives Go for exactly one accepted edge; returns 1ns after that edge.
    task automatic start12(input logic [3:0] nv);
        @(negedge CLK);
        if12.n  = nv;
        if12.Go = 1'b1;
        @(posedge CLK);
        #1;
        if12.Go = 1'b0;
    endtask

    task automatic clear12();
        @(negedge CLK);
        if12.Clr = 1'b1;
        @(posedge CLK);
        #1;
        if12.Clr = 1'b0;
    endtask

    // Counts further edges until Done or Err, bounded; also counts Busy cycles.
    task automatic wait12(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        while (!if12.Done && !if12.Err && edges < 40) begin
            if (if12.Busy) busy++;
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        #2;
        vecs++;
        if ({if12.Busy, if12.Done, if12.Err} !== 3'b000 || if12.nF !== 32'd0) begin
            errs++;
            $display("FAIL reset12: busy/done/err=%b nF=%0d, want 000 0",
                     {if12.Busy, if12.Done, if12.Err}, if12.nF);
        end
        vecs++;
        if ({if15.Busy, if15.Done, if15.Err} !== 3'b000 || if15.nF !== 32'd0) begin
            errs++;
            $display("FAIL reset15: busy/done/err=%b nF=%0d, want 000 0",
                     {if15.Busy, if15.Done, if15.Err}, if15.nF);
        end
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_n5();
        int e, b;
        start12(4'd5);
        wait12(e, b);
        vecs++;
        if (e !== 5) begin
            errs++;
            $display("FAIL n5_latency: %0d edges after accept edge, want 5", e);
        end
        vecs++;
        if (b !== 5) begin
            errs++;
            $display("FAIL n5_busy: busy %0d cycles, want 5", b);
        end
        vecs++;
        if (if12.Done !== 1'b1 || if12.nF !== 32'd120) begin
            errs++;
            $display("FAIL n5_result: done=%b nF=%0d, want 1 120", if12.Done, if12.nF);
        end
        repeat (3) @(posedge CLK);
        #1;
        vecs++;
        if (if12.Done !== 1'b1 || if12.nF !== 32'd120) begin
            errs++;
            $display("FAIL n5_hold: done=%b nF=%0d, want 1 120", if12.Done, if12.nF);
        end
        clear12();
        vecs++;
        if (if12.Done !== 1'b0 || if12.nF !== 32'd0) begin
            errs++;
            $display("FAIL n5_clr: done=%b nF=%0d, want 0 0", if12.Done, if12.nF);
        end
    endtask

    task automatic test_small();
        int e, b;
        start12(4'd0);
        wait12(e, b);
        vecs++;
        if (e !== 1 || if12.Done !== 1'b1 || if12.nF !== 32'd1) begin
            errs++;
            $display("FAIL n0: edges=%0d done=%b nF=%0d, want 1 1 1", e, if12.Done, if12.nF);
        end
        start12(4'd1);
        vecs++;
        if (if12.Busy !== 1'b1) begin
            errs++;
            $display("FAIL restart_from_done: busy=%b, want 1", if12.Busy);
        end
        wait12(e, b);
        vecs++;
        if (e !== 1 || if12.Done !== 1'b1 || if12.nF !== 32'd1) begin
            errs++;
            $display("FAIL n1: edges=%0d done=%b nF=%0d, want 1 1 1", e, if12.Done, if12.nF);
        end
        start12(4'd12);
        wait12(e, b);
        vecs++;
        if (e !== 12 || if12.Done !== 1'b1 || if12.nF !== 32'd479001600) begin
            errs++;
            $display("FAIL n12: edges=%0d done=%b nF=%0d, want 12 1 479001600",
                     e, if12.Done, if12.nF);
        end
        clear12();
    endtask

    task automatic test_max_reject();
        int e, b;
        start12(4'd13);
        vecs++;
        if (if12.Err !== 1'b1 || if12.Busy !== 1'b0 || if12.nF !== 32'd0) begin
            errs++;
            $display("FAIL reject13: err=%b busy=%b nF=%0d, want 1 0 0",
                     if12.Err, if12.Busy, if12.nF);
        end
        repeat (2) @(posedge CLK);
        #1;
        vecs++;
        if (if12.Err !== 1'b1 || if12.Busy !== 1'b0) begin
            errs++;
            $display("FAIL reject13_hold: err=%b busy=%b, want 1 0", if12.Err, if12.Busy);
        end
        // restart straight out of ERR
        start12(4'd3);
        wait12(e, b);
        vecs++;
        if (e !== 3 || if12.Done !== 1'b1 || if12.nF !== 32'd6) begin
            errs++;
            $display("FAIL restart_from_err: edges=%0d done=%b nF=%0d, want 3 1 6",
                     e, if12.Done, if12.nF);
        end
        clear12();
    endtask

    task automatic test_overflow();
        int          e;
        int          b;
        logic [31:0] r_at;
        logic [3:0]  cnt_at;
        r_at   = '0;
        cnt_at = '0;
        @(negedge CLK);
        if15.n  = 4'd13;
        if15.Go = 1'b1;
        @(posedge CLK);
        #1;
        if15.Go = 1'b0;
        e = 0;
        b = 0;
        while (!if15.Done && !if15.Err && e < 40) begin
            if (if15.Busy) b++;
            @(posedge CLK);
            #1;
            e++;
            if (e == 11) begin
                r_at   = u_dut15.r_q;
                cnt_at = u_dut15.cnt_q;
            end
        end
        vecs++;
        if (r_at !== 32'd3113510400 || cnt_at !== 4'd2) begin
            errs++;
            $display("FAIL ovf_partial: R=%0d CNT=%0d, want 3113510400 2", r_at, cnt_at);
        end
        vecs++;
        if (e !== 12 || if15.Err !== 1'b1 || if15.Done !== 1'b0) begin
            errs++;
            $display("FAIL ovf_err: edges=%0d err=%b done=%b, want 12 1 0",
                     e, if15.Err, if15.Done);
        end
        vecs++;
        if (if15.nF !== 32'd0 || b !== 12) begin
            errs++;
            $display("FAIL ovf_nf: nF=%0d busy=%0d, want 0 12", if15.nF, b);
        end
        @(negedge CLK);
        if15.Clr = 1'b1;
        @(posedge CLK);
        #1;
        if15.Clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e, b;
        start12(4'd9);
        repeat (2) @(posedge CLK);
        #2;
        RST_n = 1'b0;
        #1;
        vecs++;
        if ({if12.Busy, if12.Done, if12.Err} !== 3'b000 || if12.nF !== 32'd0) begin
            errs++;
            $display("FAIL async_reset: busy/done/err=%b nF=%0d, want 000 0",
                     {if12.Busy, if12.Done, if12.Err}, if12.nF);
        end
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        start12(4'd4);
        wait12(e, b);
        vecs++;
        if (e !== 4 || if12.Done !== 1'b1 || if12.nF !== 32'd24) begin
            errs++;
            $display("FAIL after_reset_n4: edges=%0d done=%b nF=%0d, want 4 1 24",
                     e, if12.Done, if12.nF);
        end
        clear12();
    endtask

    task automatic test_go_ignored();
        int e, b;
        start12(4'd6);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        if12.n  = 4'd3;
        if12.Go = 1'b1;
        @(posedge CLK);
        #1;
        if12.Go = 1'b0;
        if12.n  = 4'd2;
        wait12(e, b);
        vecs++;
        if (e + 2 !== 6 || if12.Done !== 1'b1 || if12.nF !== 32'd720) begin
            errs++;
            $display("FAIL go_in_calc: edges=%0d done=%b nF=%0d, want 6 1 720",
                     e + 2, if12.Done, if12.nF);
        end
        @(negedge CLK);
        if12.Clr = 1'b1;
        if12.Go  = 1'b1;
        if12.n   = 4'd5;
        @(posedge CLK);
        #1;
        if12.Clr = 1'b0;
        if12.Go  = 1'b0;
        vecs++;
        if ({if12.Busy, if12.Done, if12.Err} !== 3'b000 || if12.nF !== 32'd0) begin
            errs++;
            $display("FAIL clr_beats_go: busy/done/err=%b nF=%0d, want 000 0",
                     {if12.Busy, if12.Done, if12.Err}, if12.nF);
        end
        @(posedge CLK);
        #1;
        vecs++;
        if ({if12.Busy, if12.Done, if12.Err} !== 3'b000) begin
            errs++;
            $display("FAIL clr_stays_idle: busy/done/err=%b, want 000",
                     {if12.Busy, if12.Done, if12.Err});
        end
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        RST_n    = 1'b0;
        if12.Go  = 1'b0;
        if12.Clr = 1'b0;
        if12.n   = '0;
        if15.Go  = 1'b0;
        if15.Clr = 1'b0;
        if15.n   = '0;
        test_reset();
        test_n5();
        test_small();
        test_max_reject();
        test_overflow();
        test_reset_mid();
        test_go_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
